// File: rtl/circuit1_result_buffer.sv
// Result buffer for the Circuit1 datapath: a show-ahead FIFO of (z, x) pairs with
// a valid/ready consumer port, plus running statistics over every accepted sample.
module circuit1_result_buffer #(
   parameter int DEPTH = 4,
   parameter int ZW    = 8,
   parameter int XW    = 16,
   parameter int SW    = 24,
   parameter int CW    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ZW-1:0]             z_in,
   input  logic [XW-1:0]             x_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ZW-1:0]             out_z,
   output logic [XW-1:0]             out_x,
   output logic [$clog2(DEPTH):0]    level,
   output logic [SW-1:0]             sum_x,
   output logic [ZW-1:0]             max_z,
   output logic [CW-1:0]             n_samples,
   output logic                      sat_flag,
   output logic                      drop_flag,
   input  logic                      clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [ZW-1:0] mem_z_q [DEPTH];
   logic [XW-1:0] mem_x_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   logic [SW-1:0] sum_q, sum_d;
   logic [SW:0]   sum_ext;
   logic [ZW-1:0] max_q, max_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sat_q, sat_d;
   logic          drop_q, drop_d;

   logic push, pop;

   // Handshake status depends on stored state only, never on the inputs.
   assign in_ready  = (level_q != LW'(DEPTH));
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_z = out_valid ? mem_z_q[rd_ptr_q] : '0;
   assign out_x = out_valid ? mem_x_q[rd_ptr_q] : '0;

   // NOTE: storage has no reset; stale entries are masked by level, so clearing them buys nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_z_q[wr_ptr_q] <= z_in;
         mem_x_q[wr_ptr_q] <= x_in;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      sum_d   = sum_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      drop_d  = drop_q;
      sum_ext = '0;
      if (clr) begin
         sum_d  = '0;
         max_d  = '0;
         cnt_d  = '0;
         sat_d  = 1'b0;
         drop_d = 1'b0;
      end
      // A clear in the same cycle as a push leaves exactly that one sample in the stats.
      if (push) begin
         sum_ext = {1'b0, sum_d} + {{(SW + 1 - XW){1'b0}}, x_in};
         if (sum_ext[SW] || (&sum_ext[SW-1:0])) begin
            sum_d = '1;
            sat_d = 1'b1;
         end else begin
            sum_d = sum_ext[SW-1:0];
         end
         if (z_in > max_d) max_d = z_in;
         if (cnt_d != '1)  cnt_d = cnt_d + CW'(1);
      end
      if (in_valid && !in_ready) drop_d = 1'b1;
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         sum_q    <= '0;
         max_q    <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         sum_q    <= sum_d;
         max_q    <= max_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
         drop_q   <= drop_d;
      end
   end

   assign level     = level_q;
   assign sum_x     = sum_q;
   assign max_z     = max_q;
   assign n_samples = cnt_q;
   assign sat_flag  = sat_q;
   assign drop_flag = drop_q;

endmodule

// File: tb/tb_circuit1_result_buffer.sv
// Directed bench for circuit1_result_buffer: a queue scoreboard for FIFO order plus
// an independent statistics model, checked every cycle around each clock edge.
module tb_circuit1_result_buffer;

   localparam int  DEPTH = 4;
   localparam longint SMAX = (64'd1 << 24) - 1;

   typedef struct {
      logic [7:0]  z;
      logic [15:0] x;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  z_in = '0;
   logic [15:0] x_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_z;
   logic [15:0] out_x;
   logic [2:0]  level;
   logic [23:0] sum_x;
   logic [7:0]  max_z;
   logic [7:0]  n_samples;
   logic        sat_flag;
   logic        drop_flag;
   logic        clr = 1'b0;

   int checks = 0;
   int errors = 0;

   pair_t  sb[$];
   longint m_sum;
   int     m_max;
   int     m_cnt;
   bit     m_sat;
   bit     m_drop;

   circuit1_result_buffer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .z_in(z_in), .x_in(x_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_x(out_x),
      .level(level), .sum_x(sum_x), .max_z(max_z), .n_samples(n_samples),
      .sat_flag(sat_flag), .drop_flag(drop_flag), .clr(clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      sb.delete();
      m_sum = 0; m_max = 0; m_cnt = 0; m_sat = 0; m_drop = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".level"},     level,     64'(sb.size()));
      check({tag, ".sum_x"},     sum_x,     64'(m_sum));
      check({tag, ".max_z"},     max_z,     64'(m_max));
      check({tag, ".n_samples"}, n_samples, 64'(m_cnt));
      check({tag, ".sat_flag"},  sat_flag,  64'(m_sat));
      check({tag, ".drop_flag"}, drop_flag, 64'(m_drop));
   endtask

   // Called just after a falling edge; ends just after the next falling edge.
   task automatic cycle(input bit iv, input logic [7:0] z, input logic [15:0] x,
                        input bit ordy, input bit c);
      bit push_m, pop_m;
      longint s;
      in_valid = iv; z_in = z; x_in = x; out_ready = ordy; clr = c;
      #1;
      check("in_ready",  in_ready,  64'(sb.size() != DEPTH));
      check("out_valid", out_valid, 64'(sb.size() != 0));
      if (sb.size() != 0) begin
         check("out_z", out_z, 64'(sb[0].z));
         check("out_x", out_x, 64'(sb[0].x));
      end else begin
         check("out_z_empty", out_z, 64'd0);
         check("out_x_empty", out_x, 64'd0);
      end
      pop_m  = ordy && (sb.size() != 0);
      push_m = iv && (sb.size() != DEPTH);
      @(posedge clk);
      if (pop_m) void'(sb.pop_front());
      if (push_m) sb.push_back('{z: z, x: x});
      if (c) begin
         m_sum = 0; m_max = 0; m_cnt = 0; m_sat = 0; m_drop = 0;
      end
      if (push_m) begin
         s = m_sum + longint'(x);
         if (s >= SMAX) begin
            s = SMAX;
            m_sat = 1;
         end
         m_sum = s;
         if (int'(z) > m_max) m_max = int'(z);
         if (m_cnt < 255) m_cnt++;
      end
      if (iv && !push_m) m_drop = 1;
      @(negedge clk);
      check_regs("post");
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic do_reset();
      in_valid = 0; out_ready = 0; clr = 0;
      #2;
      rst = 1'b0;
      #1;
      model_clear();
      check("rst.out_valid", out_valid, 64'd0);
      check("rst.out_z",     out_z,     64'd0);
      check("rst.out_x",     out_x,     64'd0);
      check_regs("rst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst.in_ready", in_ready, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      model_clear();
      @(negedge clk);
      do_reset();

      // Single push, consumer stalled.
      cycle(1, 8'd8, 16'd8, 0, 0);
      check("s1.level", level, 64'd1);
      check("s1.sum_x", sum_x, 64'd8);
      cycle(0, 8'd0, 16'd0, 0, 0);

      // Fill to full, drop a fifth sample, then drain in order.
      do_reset();
      cycle(1, 8'd8,   16'd8,   0, 0);
      cycle(1, 8'd12,  16'd9,   0, 0);
      cycle(1, 8'd5,   16'd100, 0, 0);
      cycle(1, 8'd200, 16'd1,   0, 0);
      check("s2.sum_x", sum_x, 64'd118);
      check("s2.max_z", max_z, 64'd200);
      cycle(1, 8'd77, 16'd77, 0, 0);
      check("s2.drop_flag", drop_flag, 64'd1);
      for (int i = 0; i < 4; i++) cycle(0, 8'd0, 16'd0, 1, 0);
      cycle(0, 8'd0, 16'd0, 1, 0);

      // Steady streaming at level 3 across pointer wrap.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, 8'(i), 16'(i), 0, 0);
      for (int i = 3; i < 13; i++) cycle(1, 8'(i * 7), 16'(i), 1, 0);
      check("s3.level", level, 64'd3);
      for (int i = 0; i < 4; i++) cycle(0, 8'd0, 16'd0, 1, 0);

      // Full with push and pop together: pop only, sample dropped.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 8'(i + 40), 16'(i + 1000), 0, 0);
      cycle(1, 8'd99, 16'd99, 1, 0);
      check("s4.level", level, 64'd3);
      check("s4.drop_flag", drop_flag, 64'd1);
      // Clear together with a drop: the new drop wins.
      cycle(1, 8'd1, 16'd1, 0, 0);
      cycle(1, 8'd2, 16'd2, 0, 1);
      check("s4.clr_drop", drop_flag, 64'd1);
      for (int i = 0; i < 4; i++) cycle(0, 8'd0, 16'd0, 1, 0);

      // Saturation of sum and count, then clear with a push.
      do_reset();
      for (int i = 0; i < 300; i++) cycle(1, 8'(i), 16'hFFFF, 1, 0);
      check("s5.sum_sat", sum_x, 64'hFFFFFF);
      check("s5.sat_flag", sat_flag, 64'd1);
      check("s5.n_sat", n_samples, 64'hFF);
      cycle(1, 8'd3, 16'd5, 1, 1);
      check("s5.clr_sum", sum_x, 64'd5);
      check("s5.clr_n", n_samples, 64'd1);
      check("s5.clr_sat", sat_flag, 64'd0);
      cycle(0, 8'd0, 16'd0, 1, 0);

      // Asynchronous reset with two entries stored, then a fresh push.
      cycle(1, 8'd11, 16'd21, 0, 0);
      cycle(1, 8'd12, 16'd22, 0, 0);
      check("s6.level_pre", level, 64'd2);
      do_reset();
      cycle(1, 8'd8, 16'd8, 0, 0);
      cycle(0, 8'd0, 16'd0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
